cmd_exec_sched: RTL and testbench

//  Scheduler between the 3-bit command FIFO wrapper and the command-execution engine.

---
 rtl/cmd_exec_sched.sv | 144 ++++++++++++++
 tb/tb_cmd_exec_sched.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_exec_sched.sv
// Command scheduler: pops one command from the queue, launches it on the engine,
// waits for completion or timeout, and keeps completion/error counters.
module cmd_exec_sched #(
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned RETRY_GAP   = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             I_clk,
    input  logic             I_rst_n,
    input  logic             I_enable,
    output logic             O_pop,
    input  logic             I_cmd_valid,
    input  logic [2:0]       I_cmd_data,
    output logic             O_start,
    output logic [2:0]       O_opcode,
    input  logic             I_busy,
    input  logic             I_done,
    output logic             O_active,
    output logic             O_err,
    output logic [CNT_W-1:0] O_done_cnt,
    output logic [CNT_W-1:0] O_err_cnt
);

    localparam int unsigned TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned GAP_W = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RETRY_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_WAIT_Q,
        S_LAUNCH,
        S_RUN,
        S_FINISH,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [2:0]       opcode_d;
    logic             start_d;
    logic             err_d;
    logic             done_inc;
    logic             err_inc;
    logic             timeout_hit;

    // The timer equals the number of cycles since the launch pulse.
    assign timeout_hit = (TIMEOUT_CYC != 0) && (tmr_q >= TMR_LAST);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves
        // a value unassigned and no latch is inferred.
        state_d  = state_q;
        opcode_d = O_opcode;
        start_d  = 1'b0;
        err_d    = 1'b0;
        done_inc = 1'b0;
        err_inc  = 1'b0;
        tmr_d    = '0;
        gap_d    = '0;

        case (state_q)
            S_IDLE: begin
                if (I_enable) state_d = S_POP;
            end
            S_POP: begin
                state_d = S_WAIT_Q;
            end
            S_WAIT_Q: begin
                if (!I_cmd_valid) begin
                    state_d = S_GAP;
                end else if (I_cmd_data != 3'd0) begin
                    opcode_d = I_cmd_data;
                    start_d  = !I_busy;
                    state_d  = S_LAUNCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: begin
                // The launch pulse is registered, so it occupies the last LAUNCH cycle.
                if (O_start) begin
                    tmr_d   = tmr_q + 1'b1;
                    state_d = S_RUN;
                end else begin
                    start_d = !I_busy;
                end
            end
            S_RUN: begin
                tmr_d = tmr_q + 1'b1;
                if (I_done) begin
                    done_inc = 1'b1;
                    state_d  = S_FINISH;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    err_inc = 1'b1;
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                opcode_d = 3'd0;
                state_d  = S_IDLE;
            end
            S_GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GAP_LAST) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q    <= S_IDLE;
            tmr_q      <= '0;
            gap_q      <= '0;
            O_pop      <= 1'b0;
            O_start    <= 1'b0;
            O_opcode   <= 3'd0;
            O_active   <= 1'b0;
            O_err      <= 1'b0;
            O_done_cnt <= '0;
            O_err_cnt  <= '0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            gap_q    <= gap_d;
            O_pop    <= (state_d == S_POP);
            O_start  <= start_d;
            O_opcode <= opcode_d;
            O_active <= state_d inside {S_POP, S_WAIT_Q, S_LAUNCH, S_RUN, S_FINISH};
            O_err    <= err_d;
            if (done_inc) O_done_cnt <= O_done_cnt + 1'b1;
            if (err_inc && (O_err_cnt != '1)) O_err_cnt <= O_err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_cmd_exec_sched.sv
// Self-checking bench for cmd_exec_sched: directed scenarios with literal timing
// checks plus randomized traffic compared every cycle against a behavioural model.
module tb_cmd_exec_sched;

    localparam int TIMEOUT_CYC = 16;
    localparam int RETRY_GAP   = 8;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;
    localparam int W_POP   = 0;
    localparam int W_START = 1;
    localparam int W_ERR   = 2;

    logic             I_clk;
    logic             I_rst_n;
    logic             I_enable;
    logic             O_pop;
    logic             I_cmd_valid;
    logic [2:0]       I_cmd_data;
    logic             O_start;
    logic [2:0]       O_opcode;
    logic             I_busy;
    logic             I_done;
    logic             O_active;
    logic             O_err;
    logic [CNT_W-1:0] O_done_cnt;
    logic [CNT_W-1:0] O_err_cnt;

    cmd_exec_sched #(
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .RETRY_GAP  (RETRY_GAP),
        .CNT_W      (CNT_W)
    ) dut (
        .I_clk      (I_clk),
        .I_rst_n    (I_rst_n),
        .I_enable   (I_enable),
        .O_pop      (O_pop),
        .I_cmd_valid(I_cmd_valid),
        .I_cmd_data (I_cmd_data),
        .O_start    (O_start),
        .O_opcode   (O_opcode),
        .I_busy     (I_busy),
        .I_done     (I_done),
        .O_active   (O_active),
        .O_err      (O_err),
        .O_done_cnt (O_done_cnt),
        .O_err_cnt  (O_err_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_n = 0;
    int win_start = 0;
    int win_err = 0;
    bit model_go = 0;
    bit model_en = 0;
    int q_kind = 1;          // 0 random queue, 1 fixed value q_val, 2 empty
    int q_val = 5;

    // Expected outputs for the current cycle, written by the model at each rising edge.
    int m_pop, m_start, m_active, m_err, m_op, m_done_cnt, m_err_cnt;

    initial begin
        I_clk = 1'b0;
        forever #5 I_clk = ~I_clk;
    end

    initial forever begin
        @(posedge I_clk);
        cyc_n++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    task automatic cyc();
        @(negedge I_clk);
        #1;
    endtask

    function automatic bit sel(input int which);
        case (which)
            W_POP:   return O_pop;
            W_START: return O_start;
            W_ERR:   return O_err;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int which, input string nm, output int t);
        int n = 0;
        while (!sel(which) && n < 400) begin
            cyc();
            n++;
        end
        check({nm, "_seen"}, sel(which), 1);
        t = cyc_n;
    endtask

    // Queue responder: answers in the cycle after a pop; drives noise elsewhere in random mode.
    initial begin
        bit pop_prev = 0;
        int r;
        I_cmd_valid = 1'b0;
        I_cmd_data  = 3'd0;
        forever begin
            @(negedge I_clk);
            if (pop_prev) begin
                case (q_kind)
                    1: begin I_cmd_valid = 1'b1; I_cmd_data = 3'(q_val); end
                    2: begin I_cmd_valid = 1'b0; I_cmd_data = 3'd0; end
                    default: begin
                        r = $urandom_range(9);
                        I_cmd_valid = (r >= 2);
                        I_cmd_data  = (r < 3) ? 3'd0 : 3'($urandom_range(7, 1));
                    end
                endcase
            end else if (q_kind == 0) begin
                I_cmd_valid = ($urandom_range(3) == 0);
                I_cmd_data  = 3'($urandom_range(7));
            end else begin
                I_cmd_valid = 1'b0;
                I_cmd_data  = 3'd0;
            end
            pop_prev = O_pop;
        end
    end

    initial forever begin
        @(negedge I_clk);
        win_start += int'(O_start);
        win_err   += int'(O_err);
    end

    // Behavioural model: walks one command at a time through its timeline.
    initial begin : ref_model
        bit got_done;
        m_done_cnt = 0;
        m_err_cnt  = 0;
        m_pop = 0; m_start = 0; m_active = 0; m_err = 0; m_op = 0;
        wait (model_go);
        forever begin
            m_pop = 0; m_start = 0; m_active = 0; m_err = 0; m_op = 0;
            @(posedge I_clk);
            while (!I_enable) @(posedge I_clk);
            m_pop = 1;
            m_active = 1;
            @(posedge I_clk);
            m_pop = 0;
            @(posedge I_clk);
            if (!I_cmd_valid) begin
                m_active = 0;
                repeat (RETRY_GAP) @(posedge I_clk);
            end else if (I_cmd_data != 3'd0) begin
                m_op = int'(I_cmd_data);
                while (I_busy) @(posedge I_clk);
                m_start = 1;
                @(posedge I_clk);
                m_start = 0;
                got_done = 0;
                for (int k = 1; k < TIMEOUT_CYC && !got_done; k++) begin
                    @(posedge I_clk);
                    got_done = I_done;
                end
                if (got_done) begin
                    m_done_cnt = (m_done_cnt + 1) % (CNT_MAX + 1);
                end else begin
                    m_err = 1;
                    m_err_cnt = (m_err_cnt == CNT_MAX) ? CNT_MAX : m_err_cnt + 1;
                end
                @(posedge I_clk);
            end
        end
    end

    initial forever begin
        @(negedge I_clk);
        if (model_en) begin
            check("pop", O_pop, m_pop);
            check("start", O_start, m_start);
            check("active", O_active, m_active);
            check("err", O_err, m_err);
            check("opcode", O_opcode, m_op);
            check("done_cnt", O_done_cnt, m_done_cnt);
            check("err_cnt", O_err_cnt, m_err_cnt);
        end
    end

    initial begin
        int tp, ts, te, t0, t1;
        I_rst_n  = 1'b1;
        I_enable = 1'b0;
        I_busy   = 1'b0;
        I_done   = 1'b0;
        #2 I_rst_n = 1'b0;
        repeat (3) cyc();
        check("rst_pop", O_pop, 0);
        check("rst_start", O_start, 0);
        check("rst_active", O_active, 0);
        check("rst_err", O_err, 0);
        check("rst_opcode", O_opcode, 0);
        check("rst_done_cnt", O_done_cnt, 0);
        check("rst_err_cnt", O_err_cnt, 0);
        I_rst_n  = 1'b1;
        model_go = 1;
        model_en = 1;

        // T1: single command 5, engine idle, done 10 cycles after launch
        q_kind = 1; q_val = 5;
        cyc();
        I_enable = 1'b1;
        wait_for(W_POP, "t1_pop", tp);
        wait_for(W_START, "t1_start", ts);
        I_enable = 1'b0;
        check("t1_pop_to_start", ts - tp, 2);
        check("t1_opcode", O_opcode, 5);
        repeat (9) cyc();
        I_done = 1'b1;
        cyc();
        I_done = 1'b0;
        check("t1_done_cnt", O_done_cnt, 1);
        cyc();
        check("t1_idle_active", O_active, 0);
        check("t1_idle_opcode", O_opcode, 0);

        // T2: empty queue -> pop period RETRY_GAP+3, never a launch
        q_kind = 2;
        win_start = 0;
        I_enable = 1'b1;
        wait_for(W_POP, "t2_pop_a", t0);
        cyc();
        wait_for(W_POP, "t2_pop_b", t1);
        check("t2_pop_period", t1 - t0, RETRY_GAP + 3);
        check("t2_no_start", win_start, 0);

        // T3: NOP commands -> pop every 3 cycles, counters untouched
        q_kind = 1; q_val = 0;
        win_start = 0;
        cyc();
        wait_for(W_POP, "t3_pop_a", t0);
        cyc();
        wait_for(W_POP, "t3_pop_b", t1);
        check("t3_pop_period", t1 - t0, 3);
        check("t3_no_start", win_start, 0);
        check("t3_done_cnt", O_done_cnt, 1);
        check("t3_err_cnt", O_err_cnt, 0);
        I_enable = 1'b0;
        repeat (12) cyc();

        // T4: no done -> error TIMEOUT_CYC cycles after launch, then the next pop
        q_val = 3;
        I_enable = 1'b1;
        wait_for(W_START, "t4_start", ts);
        wait_for(W_ERR, "t4_err", te);
        check("t4_start_to_err", te - ts, TIMEOUT_CYC);
        check("t4_err_cnt", O_err_cnt, 1);
        wait_for(W_POP, "t4_next_pop", tp);
        check("t4_err_to_pop", tp - te, 2);
        I_enable = 1'b0;
        repeat (25) cyc();

        // T5: engine busy for 5 LAUNCH cycles -> launch the cycle after busy falls
        q_val = 6;
        I_busy = 1'b1;
        I_enable = 1'b1;
        wait_for(W_POP, "t5_pop", tp);
        I_enable = 1'b0;
        repeat (7) cyc();
        I_busy = 1'b0;
        wait_for(W_START, "t5_start", ts);
        check("t5_start_cycle", ts - tp, 8);
        check("t5_opcode", O_opcode, 6);
        repeat (2) cyc();
        I_done = 1'b1;
        cyc();
        I_done = 1'b0;
        check("t5_done_cnt", O_done_cnt, 2);
        check("t5_err_cnt", O_err_cnt, 2);

        // T6a: done on the timeout cycle wins over the error
        repeat (3) cyc();
        q_val = 7;
        I_enable = 1'b1;
        wait_for(W_START, "t6_start", ts);
        I_enable = 1'b0;
        win_err = 0;
        repeat (TIMEOUT_CYC - 1) cyc();
        I_done = 1'b1;
        cyc();
        I_done = 1'b0;
        check("t6_active_finish", O_active, 1);
        check("t6_no_err", O_err, 0);
        check("t6_done_cnt", O_done_cnt, 3);
        check("t6_err_cnt", O_err_cnt, 2);
        repeat (3) cyc();
        check("t6_no_err_pulse", win_err, 0);

        // Randomized traffic: enable, busy, done and queue contents all vary
        q_kind = 0;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            I_enable = ($urandom_range(7) != 0);
            if ($urandom_range(3) == 0) I_busy = ($urandom_range(2) == 0);
            I_done = ($urandom_range(9) == 0);
        end
        I_done = 1'b0;
        I_busy = 1'b0;

        // Back-to-back timeouts drive the error counter into saturation
        q_kind = 1; q_val = 1;
        I_enable = 1'b1;
        repeat (16 * 20 + 40) cyc();
        I_enable = 1'b0;
        repeat (25) cyc();
        check("sat_err_cnt", O_err_cnt, CNT_MAX);

        // T6b: reset in the middle of RUN
        q_val = 2;
        I_enable = 1'b1;
        wait_for(W_START, "t6b_start", ts);
        I_enable = 1'b0;
        repeat (3) cyc();
        model_en = 0;
        I_rst_n = 1'b0;
        #1;
        check("mid_rst_pop", O_pop, 0);
        check("mid_rst_start", O_start, 0);
        check("mid_rst_active", O_active, 0);
        check("mid_rst_err", O_err, 0);
        check("mid_rst_opcode", O_opcode, 0);
        check("mid_rst_done_cnt", O_done_cnt, 0);
        check("mid_rst_err_cnt", O_err_cnt, 0);
        repeat (2) cyc();
        I_rst_n = 1'b1;
        repeat (2) cyc();
        check("post_rst_active", O_active, 0);
        check("post_rst_pop", O_pop, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
